plot_scheduler: RTL and testbench
=================================

PLOT_SCHEDULER -- requirements
Module: plot_scheduler

Interface
REQ-001 SHALL have parameter SCREEN_W, default 160, the number of pixel columns.
REQ-002 SHALL have parameter SCREEN_H, default 120, the number of pixel rows.
REQ-003 SHALL have port clock  input  1  as the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port reset  input  1  as the asynchronous, active-high reset.
REQ-005 SHALL have port cpu_valid  input  1  to signal that a CPU plot request is offered.
REQ-006 SHALL have port cpu_ready  output  1  to signal that the request buffer is empty and will accept an offered request.
REQ-007 SHALL have ports cpu_x  input  8, cpu_y  input  7 and cpu_color  input  15  carrying the CPU pixel coordinates and colour.
REQ-008 SHALL have port clear_start  input  1  as a single-cycle request to fill the whole screen.
REQ-009 SHALL have port clear_color  input  15  as the fill colour, sampled when clear_start is accepted.
REQ-010 SHALL have port clear_busy  output  1  asserted while a fill is in progress.
REQ-011 SHALL have ports vga_x  output  8, vga_y  output  7, vga_color  output  15 and vga_plot  output  1  driving the framebuffer write port.
REQ-012 SHALL have port drop_flag  output  1  as a sticky flag for rejected out-of-range plots (feature-dependent, see REQ-029).

Function
REQ-013 SHALL hold a one-entry CPU buffer; handshake occurs when cpu_valid and cpu_ready are both high on a clock edge.
REQ-014 SHALL drive cpu_ready high exactly when the buffer is empty, with no dependence on cpu_valid.
REQ-015 SHALL implement the FSM states IDLE and CLEAR.
REQ-016 IDLE: a full buffer SHALL issue one registered write (vga_plot=1 with the buffered x/y/colour) on the next edge, and the buffer SHALL empty on that same edge.
REQ-017 SHALL give a request accepted into an empty buffer in IDLE a latency of 2 edges from the handshake edge to vga_plot high.
REQ-018 SHALL NOT allow back-to-back accept and issue to overlap: the buffer becomes available again after it is issued, so sustained throughput is one plot per 2 cycles.
REQ-019 IDLE with clear_start high SHALL go to CLEAR, latch clear_color, and set the counters x=0, y=0; clear_start SHALL win over a pending buffered write.
REQ-020 CLEAR SHALL issue vga_plot=1 on every cycle, scanning x from 0 to SCREEN_W-1 and then incrementing y.
REQ-021 SHALL, after the write at x=SCREEN_W-1, y=SCREEN_H-1 (SCREEN_W*SCREEN_H writes in total), return to IDLE with vga_plot=0 on the following cycle.
REQ-022 SHALL ignore clear_start while in CLEAR; the fill SHALL NOT restart.
REQ-023 SHALL hold the CPU buffer during CLEAR (cpu_ready=0 if it is full) and issue the buffered write on the first IDLE cycle after the fill completes.
REQ-024 SHALL drive clear_busy high for the CLEAR state only.
REQ-025 SHALL drive vga_plot low in every cycle in which no write is issued; vga_x, vga_y and vga_color then hold their last values.

Reset
REQ-026 Reset SHALL force the state to IDLE, empty the buffer, and clear the counters.
REQ-027 Reset SHALL set vga_plot=0, vga_x=0, vga_y=0, vga_color=0, clear_busy=0, cpu_ready=1 and drop_flag=0.
REQ-028 Reset asserted mid-fill SHALL abort the fill immediately, with no further writes issued.

Configuration
REQ-029 With macro PLOT_BOUNDS_CHECK_EN defined:
- An accepted request with cpu_x>=SCREEN_W or cpu_y>=SCREEN_H SHALL be discarded and SHALL NOT be buffered.
- drop_flag SHALL set and stay set until reset.
REQ-030 Without PLOT_BOUNDS_CHECK_EN, all requests SHALL be buffered and issued, and drop_flag SHALL be tied to 0.

Structure
REQ-031 Shared package plot_pkg SHALL hold:
- the FSM state encoding;
- the coordinate and colour width constants (8, 7, 15);
- the default screen dimensions.
REQ-032 The scan counter SHALL be the sub-module plot_scan_counter (x/y wrap counter with a done output).

Verification
REQ-033 After reset: cpu_x=5, cpu_y=7, cpu_color=0x7FFF handshaken -> two edges later vga_plot=1, vga_x=5, vga_y=7, vga_color=0x7FFF for one cycle.
REQ-034 clear_start with clear_color=0x001F -> clear_busy high for 19200 cycles; the last write is at (159,119) and vga_plot=0 on the next cycle.
REQ-035 CPU request (10,10) buffered during CLEAR -> cpu_ready=0 throughout; the write at (10,10) occurs on the first cycle after clear_busy falls.
REQ-036 clear_start pulsed again at write 100 -> the fill is not restarted and the total write count is still 19200.
REQ-037 Reset at write 500 of a fill -> the next cycle has vga_plot=0, clear_busy=0 and cpu_ready=1.
REQ-038 With PLOT_BOUNDS_CHECK_EN, request (160,0) -> no write is issued and drop_flag=1 until reset.

Source files
------------

// File: rtl/plot_pkg.sv
// Shared definitions for the pixel plot scheduler: FSM state encoding,
// coordinate/colour widths and default screen dimensions.
package plot_pkg;

    localparam int unsigned XW = 8;   // vga/cpu x coordinate width
    localparam int unsigned YW = 7;   // vga/cpu y coordinate width
    localparam int unsigned CW = 15;  // colour width

    localparam int unsigned SCREEN_W_DEF = 160;
    localparam int unsigned SCREEN_H_DEF = 120;

    typedef enum logic [0:0] {
        StIdle,
        StClear
    } state_e;

endpackage

// File: rtl/plot_scheduler_if.sv
// Plot scheduler bus bundle.
//   cpu_*   : one-entry CPU plot request channel (valid/ready)
//   clear_* : full-screen fill request and busy indication
//   vga_*   : registered framebuffer write port
//   drop_flag : sticky out-of-range drop indication
// Modports: master = request side / framebuffer sink, slave = scheduler.
interface plot_scheduler_if;
    import plot_pkg::*;

    logic          cpu_valid;
    logic          cpu_ready;
    logic [XW-1:0] cpu_x;
    logic [YW-1:0] cpu_y;
    logic [CW-1:0] cpu_color;

    logic          clear_start;
    logic [CW-1:0] clear_color;
    logic          clear_busy;

    logic [XW-1:0] vga_x;
    logic [YW-1:0] vga_y;
    logic [CW-1:0] vga_color;
    logic          vga_plot;

    logic          drop_flag;

    modport master (
        output cpu_valid, cpu_x, cpu_y, cpu_color, clear_start, clear_color,
        input  cpu_ready, clear_busy, vga_x, vga_y, vga_color, vga_plot, drop_flag
    );

    modport slave (
        input  cpu_valid, cpu_x, cpu_y, cpu_color, clear_start, clear_color,
        output cpu_ready, clear_busy, vga_x, vga_y, vga_color, vga_plot, drop_flag
    );

endinterface

// File: rtl/plot_scan_counter.sv
// Raster scan counter for the screen fill: x runs 0..SCREEN_W-1, then wraps
// and y increments; done_o flags the final pixel (SCREEN_W-1, SCREEN_H-1).
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clear_i      : synchronous return to (0,0), has priority over en_i
//   en_i         : advance one pixel
//   x_o, y_o     : current position
//   done_o       : current position is the last pixel
module plot_scan_counter
    import plot_pkg::*;
#(
    parameter int unsigned SCREEN_W = SCREEN_W_DEF,
    parameter int unsigned SCREEN_H = SCREEN_H_DEF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          en_i,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          done_o
);

    localparam logic [XW-1:0] XLast = XW'(SCREEN_W - 1);
    localparam logic [YW-1:0] YLast = YW'(SCREEN_H - 1);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          x_wrap;

    assign x_wrap = (x_q == XLast);

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clear_i) begin
            x_d = '0;
            y_d = '0;
        end else if (en_i) begin
            if (x_wrap) begin
                x_d = '0;
                y_d = (y_q == YLast) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign done_o = x_wrap && (y_q == YLast);

endmodule

// File: rtl/plot_scheduler.sv
// Pixel plot scheduler: arbitrates between single CPU plot requests (held in a
// one-entry buffer) and a full-screen fill, driving one registered framebuffer
// write port.
// Ports:
//   clock  : single clock, rising edge
//   reset  : asynchronous active-high reset
//   bus_io : plot_scheduler_if slave modport (cpu_*, clear_*, vga_*, drop_flag)
// Build option: define PLOT_BOUNDS_CHECK_EN to discard out-of-range CPU
// requests and raise the sticky drop_flag; otherwise every request is written
// and drop_flag is tied low.
module plot_scheduler
    import plot_pkg::*;
#(
    parameter int unsigned SCREEN_W = SCREEN_W_DEF,
    parameter int unsigned SCREEN_H = SCREEN_H_DEF
) (
    input  logic              clock,
    input  logic              reset,
    plot_scheduler_if.slave   bus_io
);

    state_e        state_q, state_d;

    logic          buf_full_q, buf_full_d;
    logic [XW-1:0] buf_x_q, buf_x_d;
    logic [YW-1:0] buf_y_q, buf_y_d;
    logic [CW-1:0] buf_color_q, buf_color_d;

    logic          vga_plot_q, vga_plot_d;
    logic [XW-1:0] vga_x_q, vga_x_d;
    logic [YW-1:0] vga_y_q, vga_y_d;
    logic [CW-1:0] vga_color_q, vga_color_d;

    logic [CW-1:0] clr_color_q, clr_color_d;

    logic          cnt_clear, cnt_en, cnt_done;
    logic [XW-1:0] cnt_x;
    logic [YW-1:0] cnt_y;

    logic          accept;
    logic          in_range;

    // Ready depends only on buffer occupancy, so accept and issue never overlap.
    assign accept = bus_io.cpu_valid && !buf_full_q;

`ifdef PLOT_BOUNDS_CHECK_EN
    logic drop_q, drop_d;

    assign in_range = (32'(bus_io.cpu_x) < SCREEN_W) && (32'(bus_io.cpu_y) < SCREEN_H);
    assign drop_d   = drop_q || (accept && !in_range);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drop_q <= 1'b0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign bus_io.drop_flag = drop_q;
`else
    assign in_range         = 1'b1;
    assign bus_io.drop_flag = 1'b0;
`endif

    plot_scan_counter #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_scan (
        .clk_i   (clock),
        .rst_i   (reset),
        .clear_i (cnt_clear),
        .en_i    (cnt_en),
        .x_o     (cnt_x),
        .y_o     (cnt_y),
        .done_o  (cnt_done)
    );

    always_comb begin
        state_d     = state_q;
        buf_full_d  = buf_full_q;
        buf_x_d     = buf_x_q;
        buf_y_d     = buf_y_q;
        buf_color_d = buf_color_q;
        vga_plot_d  = 1'b0;
        vga_x_d     = vga_x_q;
        vga_y_d     = vga_y_q;
        vga_color_d = vga_color_q;
        clr_color_d = clr_color_q;
        cnt_clear   = 1'b0;
        cnt_en      = 1'b0;

        case (state_q)
            StIdle: begin
                // A fill request takes priority; any buffered write waits for it.
                if (bus_io.clear_start) begin
                    state_d     = StClear;
                    clr_color_d = bus_io.clear_color;
                    cnt_clear   = 1'b1;
                end else if (buf_full_q) begin
                    vga_plot_d  = 1'b1;
                    vga_x_d     = buf_x_q;
                    vga_y_d     = buf_y_q;
                    vga_color_d = buf_color_q;
                    buf_full_d  = 1'b0;
                end
            end
            StClear: begin
                vga_plot_d  = 1'b1;
                vga_x_d     = cnt_x;
                vga_y_d     = cnt_y;
                vga_color_d = clr_color_q;
                cnt_en      = 1'b1;
                if (cnt_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // accept implies an empty buffer, so this never collides with an issue.
        if (accept && in_range) begin
            buf_full_d  = 1'b1;
            buf_x_d     = bus_io.cpu_x;
            buf_y_d     = bus_io.cpu_y;
            buf_color_d = bus_io.cpu_color;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            buf_full_q  <= 1'b0;
            buf_x_q     <= '0;
            buf_y_q     <= '0;
            buf_color_q <= '0;
            vga_plot_q  <= 1'b0;
            vga_x_q     <= '0;
            vga_y_q     <= '0;
            vga_color_q <= '0;
            clr_color_q <= '0;
        end else begin
            state_q     <= state_d;
            buf_full_q  <= buf_full_d;
            buf_x_q     <= buf_x_d;
            buf_y_q     <= buf_y_d;
            buf_color_q <= buf_color_d;
            vga_plot_q  <= vga_plot_d;
            vga_x_q     <= vga_x_d;
            vga_y_q     <= vga_y_d;
            vga_color_q <= vga_color_d;
            clr_color_q <= clr_color_d;
        end
    end

    assign bus_io.cpu_ready  = !buf_full_q;
    assign bus_io.clear_busy = (state_q == StClear);
    assign bus_io.vga_plot   = vga_plot_q;
    assign bus_io.vga_x      = vga_x_q;
    assign bus_io.vga_y      = vga_y_q;
    assign bus_io.vga_color  = vga_color_q;

endmodule

// File: tb/tb_plot_scheduler.sv
// Self-checking bench for plot_scheduler: stimulus pushes expected writes into
// a queue, a negedge monitor pops and compares every vga_plot write.
module tb_plot_scheduler;

    typedef struct packed {
        logic [7:0]  x;
        logic [6:0]  y;
        logic [14:0] c;
    } wr_t;

    logic clk;
    logic rst;

    plot_scheduler_if bus ();

    plot_scheduler #(
        .SCREEN_W (160),
        .SCREEN_H (120)
    ) dut (
        .clock  (clk),
        .reset  (rst),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_errors = 0;
    int  wr_count = 0;
    int  busy_cnt = 0;
    int  cyc      = 0;
    int  last_cyc = 0;
    int  prev_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every issued write must match the head of the expected queue.
    always @(negedge clk) begin
        wr_t e;
        cyc++;
        if (bus.clear_busy) busy_cnt++;
        if (!rst && bus.vga_plot) begin
            wr_count++;
            prev_cyc = last_cyc;
            last_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_write", {2'b0, bus.vga_x, bus.vga_y, bus.vga_color}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("vga_write", {2'b0, bus.vga_x, bus.vga_y, bus.vga_color}, {2'b0, e});
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        n_errors++;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a request until it is handshaken; returns at handshake edge + 1.
    task automatic send(input logic [7:0] x, input logic [6:0] y, input logic [14:0] c,
                        input bit expect_wr);
        bit done = 1'b0;
        bus.cpu_valid = 1'b1;
        bus.cpu_x     = x;
        bus.cpu_y     = y;
        bus.cpu_color = c;
        for (int i = 0; i < 100 && !done; i++) begin
            if (bus.cpu_ready) begin
                if (expect_wr) exp_q.push_back({x, y, c});
                done = 1'b1;
            end
            tick();
        end
        bus.cpu_valid = 1'b0;
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic push_fill(input logic [14:0] c);
        for (int yy = 0; yy < 120; yy++) begin
            for (int xx = 0; xx < 160; xx++) begin
                exp_q.push_back({8'(xx), 7'(yy), c});
            end
        end
    endtask

    initial begin
        int base_wr;
        int base_busy;
        int ready_hi;
        bit hit;

        rst             = 1'b1;
        bus.cpu_valid   = 1'b0;
        bus.cpu_x       = '0;
        bus.cpu_y       = '0;
        bus.cpu_color   = '0;
        bus.clear_start = 1'b0;
        bus.clear_color = '0;
        repeat (3) tick();

        check("rst_vga_plot", 32'(bus.vga_plot), 32'd0);
        check("rst_vga_x", 32'(bus.vga_x), 32'd0);
        check("rst_vga_y", 32'(bus.vga_y), 32'd0);
        check("rst_vga_color", 32'(bus.vga_color), 32'd0);
        check("rst_clear_busy", 32'(bus.clear_busy), 32'd0);
        check("rst_cpu_ready", 32'(bus.cpu_ready), 32'd1);
        check("rst_drop_flag", 32'(bus.drop_flag), 32'd0);
        rst = 1'b0;
        repeat (2) tick();

        // Single request: write appears two edges after the handshake edge.
        send(8'd5, 7'd7, 15'h7FFF, 1'b1);
        check("lat_plot_e0", 32'(bus.vga_plot), 32'd0);
        check("lat_ready_full", 32'(bus.cpu_ready), 32'd0);
        tick();
        check("lat_plot_e1", 32'(bus.vga_plot), 32'd1);
        check("lat_x", 32'(bus.vga_x), 32'd5);
        check("lat_y", 32'(bus.vga_y), 32'd7);
        check("lat_color", 32'(bus.vga_color), 32'h7FFF);
        check("lat_ready_again", 32'(bus.cpu_ready), 32'd1);
        tick();
        check("lat_plot_one_cycle", 32'(bus.vga_plot), 32'd0);
        check("hold_x", 32'(bus.vga_x), 32'd5);

        // Back-to-back requests, distinct patterns.
        send(8'd0, 7'd0, 15'h0001, 1'b1);
        send(8'd159, 7'd119, 15'h5555, 1'b1);
        send(8'd80, 7'd60, 15'h2AAA, 1'b1);
        repeat (4) tick();
        check("b2b_gap", 32'(last_cyc - prev_cyc), 32'd2);
        check("b2b_drain", 32'(exp_q.size()), 32'd0);

        // Full fill with a CPU write buffered during it and a stray clear_start.
        base_wr   = wr_count;
        base_busy = busy_cnt;
        push_fill(15'h001F);
        bus.clear_start = 1'b1;
        bus.clear_color = 15'h001F;
        tick();
        bus.clear_start = 1'b0;
        bus.clear_color = 15'h0000;
        check("fill_busy", 32'(bus.clear_busy), 32'd1);
        send(8'd10, 7'd10, 15'h1234, 1'b1);
        check("fill_ready_held", 32'(bus.cpu_ready), 32'd0);

        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            if (wr_count - base_wr >= 100) hit = 1'b1;
            else tick();
        end
        check("reach_write100", 32'(hit), 32'd1);
        bus.clear_start = 1'b1;
        bus.clear_color = 15'h7C00;
        tick();
        bus.clear_start = 1'b0;

        hit      = 1'b0;
        ready_hi = 0;
        for (int i = 0; i < 25000 && !hit; i++) begin
            if (!bus.clear_busy) hit = 1'b1;
            else begin
                if (bus.cpu_ready) ready_hi++;
                tick();
            end
        end
        check("fill_end", 32'(hit), 32'd1);
        check("fill_ready_low", 32'(ready_hi), 32'd0);
        repeat (4) tick();
        check("fill_busy_cycles", 32'(busy_cnt - base_busy), 32'd19200);
        check("fill_write_total", 32'(wr_count - base_wr), 32'd19201);
        check("cpu_after_fill_adj", 32'(last_cyc - prev_cyc), 32'd1);
        check("fill_drain", 32'(exp_q.size()), 32'd0);
        check("fill_idle_plot", 32'(bus.vga_plot), 32'd0);

        // Reset in the middle of a fill aborts it.
        base_wr = wr_count;
        push_fill(15'h03E0);
        bus.clear_start = 1'b1;
        bus.clear_color = 15'h03E0;
        tick();
        bus.clear_start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 1000 && !hit; i++) begin
            if (wr_count - base_wr >= 500) hit = 1'b1;
            else tick();
        end
        check("reach_write500", 32'(hit), 32'd1);
        rst = 1'b1;
        #1;
        exp_q.delete();
        check("abort_plot", 32'(bus.vga_plot), 32'd0);
        check("abort_busy", 32'(bus.clear_busy), 32'd0);
        check("abort_ready", 32'(bus.cpu_ready), 32'd1);
        tick();
        rst = 1'b0;
        base_wr = wr_count;
        repeat (5) tick();
        check("abort_no_writes", 32'(wr_count - base_wr), 32'd0);

        // Out-of-range request.
`ifdef PLOT_BOUNDS_CHECK_EN
        send(8'd160, 7'd0, 15'h0ABC, 1'b0);
        repeat (4) tick();
        check("oob_drop_flag", 32'(bus.drop_flag), 32'd1);
        check("oob_no_write", 32'(wr_count - base_wr), 32'd0);
        send(8'd3, 7'd4, 15'h0F0F, 1'b1);
        repeat (4) tick();
        check("oob_drop_sticky", 32'(bus.drop_flag), 32'd1);
`else
        send(8'd160, 7'd0, 15'h0ABC, 1'b1);
        repeat (4) tick();
        check("oob_drop_flag", 32'(bus.drop_flag), 32'd0);
        check("oob_written", 32'(wr_count - base_wr), 32'd1);
`endif
        check("oob_drain", 32'(exp_q.size()), 32'd0);
        rst = 1'b1;
        tick();
        check("drop_after_rst", 32'(bus.drop_flag), 32'd0);
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
